multiplicador_n: RTL and testbench

MULTIPLICADOR_N -- requirements
Module: multiplicador_n

---
 rtl/multiplicador_n.sv | 123 ++++++++++++
 tb/tb_multiplicador_n.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/multiplicador_n.sv
// Sequential N-bit multiplier: unsigned shift-add or signed radix-2 Booth, one iteration per clock.
// Latency N+1 cycles from the start edge to the done pulse; start requests are ignored while busy or done.
module multiplicador_n #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             St,
  input  logic             sgn,
  input  logic [N-1:0]     mndo,
  input  logic [N-1:0]     mdor,
  output logic [2*N-1:0]   produto,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     mcand_q, mcand_d;
  logic             sgn_q,   sgn_d;
  logic [N:0]       acc_q,   acc_d;
  logic [N-1:0]     mult_q,  mult_d;
  logic             qm1_q,   qm1_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [2*N-1:0]   prod_q,  prod_d;

  logic [N:0]       ext;
  logic [N:0]       sum;
  logic [N:0]       acc_sh;
  logic [N-1:0]     mult_sh;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      sgn_q   <= 1'b0;
      acc_q   <= '0;
      mult_q  <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      sgn_q   <= sgn_d;
      acc_q   <= acc_d;
      mult_q  <= mult_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    // One iteration: add/subtract into the accumulator, then shift {acc, mult} right.
    ext = sgn_q ? {mcand_q[N-1], mcand_q} : {1'b0, mcand_q};
    sum = acc_q;
    if (sgn_q) begin
      case ({mult_q[0], qm1_q})
        2'b01:   sum = acc_q + ext;
        2'b10:   sum = acc_q - ext;
        default: sum = acc_q;
      endcase
    end else if (mult_q[0]) begin
      sum = acc_q + ext;
    end
    acc_sh  = {sgn_q & sum[N], sum[N:1]};
    mult_sh = {sum[0], mult_q[N-1:1]};

    state_d = state_q;
    mcand_d = mcand_q;
    sgn_d   = sgn_q;
    acc_d   = acc_q;
    mult_d  = mult_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;

    case (state_q)
      IDLE: begin
        if (St) begin
          mcand_d = mndo;
          mult_d  = mdor;
          sgn_d   = sgn;
          acc_d   = '0;
          qm1_d   = 1'b0;
          cnt_d   = CNT_INIT;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d  = acc_sh;
        mult_d = mult_sh;
        qm1_d  = mult_q[0];
        cnt_d  = cnt_q - CNT_LAST;
        if (cnt_q == CNT_LAST) begin
          prod_d  = {acc_sh[N-1:0], mult_sh};
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign produto = prod_q;
  assign busy    = (state_q == CALC);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_multiplicador_n.sv
// Randomised and directed bench for multiplicador_n against an integer-arithmetic product model.
module tb_multiplicador_n;

  parameter int N = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           St = 1'b0;
  logic           sgn = 1'b0;
  logic [N-1:0]   mndo = '0;
  logic [N-1:0]   mdor = '0;
  logic [2*N-1:0] produto;
  logic           busy;
  logic           done;

  int checks = 0;
  int errors = 0;

  multiplicador_n #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .St      (St),
    .sgn     (sgn),
    .mndo    (mndo),
    .mdor    (mdor),
    .produto (produto),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, want completion)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Interpret operands as plain integers and multiply.
  function automatic logic [2*N-1:0] model(input logic s, input logic [N-1:0] a, input logic [N-1:0] b);
    longint sa, sb;
    sa = longint'(a);
    sb = longint'(b);
    if (s && a[N-1]) sa = sa - (longint'(1) << N);
    if (s && b[N-1]) sb = sb - (longint'(1) << N);
    return (2*N)'(sa * sb);
  endfunction

  task automatic run_op(input string tag, input logic s, input logic [N-1:0] a,
                        input logic [N-1:0] b, input bit disturb);
    logic [2*N-1:0] exp, prev, got;
    int busy_cnt, done_cnt, lat;
    bit hold_ok;
    exp = model(s, a, b);
    prev = produto;
    @(negedge clk);
    St = 1'b1; sgn = s; mndo = a; mdor = b;
    @(negedge clk);
    St = 1'b0;
    busy_cnt = 0; done_cnt = 0; lat = 0; hold_ok = 1'b1; got = '0;
    for (int k = 1; k <= N + 4; k++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (lat == 0) begin
          lat = k;
          got = produto;
        end
      end else if (lat == 0 && produto !== prev) begin
        hold_ok = 1'b0;
      end
      if (disturb) begin
        if (k == 2 || k == N + 1) begin
          St = 1'b1; mndo = ~a; mdor = ~b; sgn = ~s;
        end else if (k == 3 || k == N + 2) begin
          St = 1'b0;
        end
      end
      @(negedge clk);
    end
    check({tag, "_result"}, 64'(got), 64'(exp));
    check({tag, "_latency"}, 64'(lat), 64'(N + 1));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(N));
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, "_hold_before_done"}, 64'(hold_ok), 64'd1);
    check({tag, "_hold_after_done"}, 64'(produto), 64'(exp));
  endtask

  task automatic reset_mid_op();
    int done_seen, busy_seen;
    logic [N-1:0] a, b;
    a = N'(32'h0000_0007);
    b = N'(32'h0000_0006);
    @(negedge clk);
    St = 1'b1; sgn = 1'b0; mndo = a; mdor = b;
    @(negedge clk);
    St = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstmid_produto", 64'(produto), 64'd0);
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_done", 64'(done), 64'd0);
    St = 1'b1;
    repeat (2) @(negedge clk);
    St = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    done_seen = 0; busy_seen = 0;
    for (int k = 0; k < N + 3; k++) begin
      @(negedge clk);
      if (done) done_seen++;
      if (busy) busy_seen++;
    end
    check("rstmid_no_done", 64'(done_seen), 64'd0);
    check("rstmid_no_busy", 64'(busy_seen), 64'd0);
    check("rstmid_produto_held", 64'(produto), 64'd0);
  endtask

  initial begin
    logic [N-1:0] all1, minv, a, b;
    logic s;
    all1 = '1;
    minv = '0;
    minv[N-1] = 1'b1;

    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_produto", 64'(produto), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_produto", 64'(produto), 64'd0);

    run_op("u_max", 1'b0, all1, all1, 1'b0);
    run_op("s_neg3x5", 1'b1, -N'(3), N'(5), 1'b0);
    run_op("s_min_sq", 1'b1, minv, minv, 1'b0);
    run_op("u_min_x2", 1'b0, minv, N'(2), 1'b0);
    run_op("s_min_x2", 1'b1, minv, N'(2), 1'b0);
    run_op("u_zero", 1'b0, '0, all1, 1'b0);
    run_op("s_zero", 1'b1, all1, '0, 1'b0);
    run_op("busy_immune", 1'b0, N'(7), N'(6), 1'b1);

    reset_mid_op();
    run_op("after_reset", 1'b0, N'(12), N'(13), 1'b0);

    for (int i = 0; i < 1000; i++) begin
      a = N'($urandom);
      b = N'($urandom);
      s = 1'($urandom);
      run_op("rand", s, a, b, 1'($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
